risc_fetch_sequencer: RTL and testbench
=======================================

# risc_fetch_sequencer

Instruction-fetch controller for the RISC CPU. It owns the fetch program counter and sequences instruction-memory requests through a req/ack handshake. It delivers one instruction at a time into a single-entry output buffer for decode, and applies stall back-pressure and branch/jump redirects from execute. It replaces free-running PC increment with a flow-controlled fetch stage.

## Interface
Parameters:
- XLEN, 32, address/PC width
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset
- INSTR_BYTES, 4, PC increment per fetched instruction

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high; sampled on posedge clk
- stall_i  input  1  decode cannot accept; holds the output buffer
- redirect_valid  input  1  redirect fetch to redirect_pc
- redirect_pc  input  XLEN  redirect target
- imem_req  output  1  memory request
- imem_addr  output  XLEN  request address; stable while imem_req is high
- imem_ack  input  1  memory response; may be asserted in the same cycle as imem_req
- imem_rdata  input  32  instruction word; valid when imem_ack is high
- instr_valid  output  1  output buffer holds an instruction
- instr  output  32  buffered instruction
- instr_pc  output  XLEN  address of instr
- pc  output  XLEN  next fetch address
- misalign_trap  output  1  one-cycle pulse on a rejected redirect (see Configuration)

## Operation
- Consume: a cycle with instr_valid && !stall_i consumes the buffer.
- Slot free: the buffer is empty, or it is consumed this cycle.
- FSM states:
  - BOOT: first cycle after reset. imem_req=0. Goes to FETCH.
  - FETCH: issues a request when the slot is free.
  - DRAIN: completes an abandoned request.
  - HOLD: buffer full and stalled. imem_req=0.
- Issue: imem_req=1 and imem_addr is latched from pc into req_addr. imem_req stays high until imem_ack. The in-flight request always has a buffer slot, because only the request itself can fill the buffer.
- Ack in FETCH, no redirect:
  - instr<=imem_rdata, instr_pc<=req_addr, instr_valid<=1.
  - pc<=pc+INSTR_BYTES, modulo 2^XLEN (0xFFFF_FFFC wraps to 0).
- FETCH, slot not free: go to HOLD. Leave HOLD on consume.
- Redirect (highest priority):
  - pc<=redirect_pc and instr_valid<=0 (flush).
  - If a request is outstanding without ack this cycle: go to DRAIN. imem_req stays high at the old imem_addr. The ack data is discarded, then the FSM returns to FETCH.
  - Redirect and ack in the same cycle: the data is discarded and the FSM goes to FETCH.
  - Redirect during DRAIN: pc is updated and the FSM stays in DRAIN.
  - Redirect in HOLD or BOOT: flush, then FETCH.
- Stall and redirect together: redirect wins. The buffer is flushed regardless of stall_i.

## Timing
- Reset values: pc=RESET_VECTOR; imem_req=0; imem_addr=0; instr_valid=0; instr=0; instr_pc=0; misalign_trap=0; state=BOOT.
- First imem_req is asserted 1 cycle after reset deasserts (after BOOT).
- With zero-wait memory (ack in the request cycle) and no stall, throughput is 1 instruction/cycle. instr_valid rises the cycle after ack.
- Redirect-to-request latency: 1 cycle in FETCH. In DRAIN, 1 cycle after the draining ack.
- Reset mid-request drops the request: imem_req is low the next cycle. The memory tolerates abandonment on reset.

## Configuration
- RISC_FETCH_ALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[1:0]!=0 is rejected: pc, buffer and state are unchanged.
  - misalign_trap is 1 for exactly the next cycle.
- RISC_FETCH_ALIGN_CHECK_EN not defined:
  - redirect_pc[1:0] is forced to 0 on capture.
  - misalign_trap is tied to 0.
- The misalign_trap port exists in both builds.

## Structure
- Package risc_pkg holds:
  - the fetch_state_t enum {BOOT, FETCH, DRAIN, HOLD}
  - the RISC_RESET_VECTOR and RISC_INSTR_BYTES constants, which are the parameter defaults
- One sub-module, risc_fetch_buffer: the single-entry instr/instr_pc/instr_valid register with load, consume and flush inputs.

## Test plan
- Reset release, ack tied high, stall_i=0 -> imem_addr sequence 0x0, 0x4, 0x8 on consecutive cycles. instr_valid is continuous from the 3rd cycle after reset.
- stall_i high for 3 cycles while instr_valid=1 -> imem_req=0 (HOLD). instr/instr_pc are stable. Fetch resumes at instr_pc+4 one cycle after stall_i falls.
- Ack delayed 3 cycles, redirect to 0x100 in the 2nd wait cycle -> imem_addr holds the old value until ack. That data never appears on instr. The next imem_addr is 0x100.
- Redirect to 0x40 in the same cycle as ack and stall_i -> buffer flushed (instr_valid=0 next cycle). The next request is at 0x40.
- pc=0xFFFF_FFFC fetched -> next imem_addr is 0x0000_0000.
- Redirect to 0x102: with the macro, misalign_trap pulses 1 cycle and pc is unchanged. Without it, the next imem_addr is 0x100. Reset asserted mid-request -> imem_req=0 and pc=RESET_VECTOR next cycle.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared types and constants for the RISC fetch sequencer.
package risc_pkg;

    localparam logic [31:0] RISC_RESET_VECTOR = 32'h0000_0000;
    localparam int unsigned RISC_INSTR_BYTES  = 4;
    localparam int unsigned RISC_INSTR_W      = 32;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        DRAIN,
        HOLD
    } fetch_state_t;

endpackage

// File: rtl/risc_fetch_buffer.sv
// Single-entry instruction buffer between fetch and decode; flush beats load beats consume.
module risc_fetch_buffer
    import risc_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic                    consume,
    input  logic                    flush,
    input  logic [RISC_INSTR_W-1:0] load_instr,
    input  logic [XLEN-1:0]         load_pc,
    output logic                    instr_valid,
    output logic [RISC_INSTR_W-1:0] instr,
    output logic [XLEN-1:0]         instr_pc
);

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else if (flush) begin
            instr_valid <= 1'b0;
        end else if (load) begin
            instr_valid <= 1'b1;
            instr       <= load_instr;
            instr_pc    <= load_pc;
        end else if (consume) begin
            instr_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/risc_fetch_sequencer.sv
// Flow-controlled instruction fetch: owns the PC, runs the imem req/ack handshake, feeds one buffer slot.
// Build option: RISC_FETCH_ALIGN_CHECK_EN rejects misaligned redirects and pulses misalign_trap.
module risc_fetch_sequencer
    import risc_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RISC_RESET_VECTOR),
    parameter int unsigned     INSTR_BYTES  = RISC_INSTR_BYTES
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_i,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] pc,
    output logic            misalign_trap
);

    fetch_state_t    state, state_d;
    logic [XLEN-1:0] pc_d, req_addr, req_addr_d, redirect_target;
    logic            pending, pending_d, trap_d;
    logic            consume, slot_free, misaligned, redirect_take;
    logic            buf_load, buf_flush;

`ifdef RISC_FETCH_ALIGN_CHECK_EN
    assign misaligned      = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign redirect_target = redirect_pc;
`else
    assign misaligned      = 1'b0;
    assign redirect_target = redirect_pc & ~XLEN'(3);
`endif

    assign redirect_take = redirect_valid && !misaligned;
    assign consume       = instr_valid && !stall_i;
    assign slot_free     = !instr_valid || consume;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= BOOT;
            pc            <= RESET_VECTOR;
            req_addr      <= '0;
            pending       <= 1'b0;
            misalign_trap <= 1'b0;
        end else begin
            state         <= state_d;
            pc            <= pc_d;
            req_addr      <= req_addr_d;
            pending       <= pending_d;
            misalign_trap <= trap_d;
        end
    end

    // A new request only starts with a free slot, so an outstanding request never finds the buffer full.
    always_comb begin
        state_d    = state;
        pc_d       = pc;
        req_addr_d = req_addr;
        pending_d  = pending;
        trap_d     = misaligned;
        imem_req   = 1'b0;
        imem_addr  = req_addr;
        buf_load   = 1'b0;
        buf_flush  = 1'b0;
        case (state)
            BOOT: begin
                state_d = FETCH;
                if (redirect_take) begin
                    pc_d      = redirect_target;
                    buf_flush = 1'b1;
                end
            end
            FETCH: begin
                if (pending) begin
                    imem_req = 1'b1;
                end else if (slot_free && !redirect_take) begin
                    imem_req   = 1'b1;
                    imem_addr  = pc;
                    req_addr_d = pc;
                    pending_d  = 1'b1;
                end
                if (redirect_take) begin
                    pc_d      = redirect_target;
                    buf_flush = 1'b1;
                    if (pending && !imem_ack) begin
                        state_d = DRAIN;
                    end else begin
                        pending_d = 1'b0;
                    end
                end else if (imem_req && imem_ack) begin
                    buf_load  = 1'b1;
                    pc_d      = pc + XLEN'(INSTR_BYTES);
                    pending_d = 1'b0;
                end else if (!slot_free) begin
                    state_d = HOLD;
                end
            end
            DRAIN: begin
                imem_req = 1'b1;
                if (redirect_take) begin
                    pc_d      = redirect_target;
                    buf_flush = 1'b1;
                end
                if (imem_ack) begin
                    pending_d = 1'b0;
                    state_d   = FETCH;
                end
            end
            HOLD: begin
                if (redirect_take) begin
                    pc_d      = redirect_target;
                    buf_flush = 1'b1;
                    state_d   = FETCH;
                end else if (consume) begin
                    state_d = FETCH;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    risc_fetch_buffer #(
        .XLEN(XLEN)
    ) u_buffer (
        .clk        (clk),
        .reset      (reset),
        .load       (buf_load),
        .consume    (consume),
        .flush      (buf_flush),
        .load_instr (imem_rdata),
        .load_pc    (imem_addr),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc)
    );

endmodule

// File: tb/tb_risc_fetch_sequencer.sv
// Directed testbench for risc_fetch_sequencer; memory returns 0xC000_0000 | address as the instruction word.
module tb_risc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc;
    logic        misalign_trap;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign imem_rdata = 32'hC000_0000 | imem_addr;

    risc_fetch_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .stall_i       (stall_i),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .pc            (pc),
        .misalign_trap (misalign_trap)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        stall_i        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_ack       = 1'b0;
        tick();
        tick();
        settle();
        check_eq("rst_req", 32'(imem_req), 32'd0);
        check_eq("rst_addr", imem_addr, 32'h0);
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_instr_pc", instr_pc, 32'h0);
        check_eq("rst_trap", 32'(misalign_trap), 32'd0);

        // Zero-wait streaming from reset.
        reset    = 1'b0;
        imem_ack = 1'b1;
        settle();
        check_eq("boot_req", 32'(imem_req), 32'd0);
        tick();
        check_eq("c2_req", 32'(imem_req), 32'd1);
        check_eq("c2_addr", imem_addr, 32'h0);
        check_eq("c2_valid", 32'(instr_valid), 32'd0);
        tick();
        check_eq("c3_addr", imem_addr, 32'h4);
        check_eq("c3_valid", 32'(instr_valid), 32'd1);
        check_eq("c3_instr_pc", instr_pc, 32'h0);
        check_eq("c3_instr", instr, 32'hC000_0000);
        tick();
        check_eq("c4_addr", imem_addr, 32'h8);
        check_eq("c4_instr_pc", instr_pc, 32'h4);
        check_eq("c4_valid", 32'(instr_valid), 32'd1);

        // Three stalled cycles: no requests, buffer frozen.
        for (int i = 0; i < 3; i++) begin
            tick();
            stall_i = 1'b1;
            settle();
            check_eq("stall_req", 32'(imem_req), 32'd0);
            check_eq("stall_instr_pc", instr_pc, 32'h8);
            check_eq("stall_instr", instr, 32'hC000_0008);
            check_eq("stall_valid", 32'(instr_valid), 32'd1);
        end
        tick();
        stall_i = 1'b0;
        settle();
        check_eq("unstall_req", 32'(imem_req), 32'd0);

        // Slow memory; redirect in the second wait cycle.
        tick();
        imem_ack = 1'b0;
        settle();
        check_eq("slow_w0_req", 32'(imem_req), 32'd1);
        check_eq("slow_w0_addr", imem_addr, 32'hC);
        tick();
        check_eq("slow_w1_addr", imem_addr, 32'hC);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        settle();
        check_eq("slow_w2_addr", imem_addr, 32'hC);
        tick();
        redirect_valid = 1'b0;
        imem_ack       = 1'b1;
        settle();
        check_eq("drain_req", 32'(imem_req), 32'd1);
        check_eq("drain_addr", imem_addr, 32'hC);
        check_eq("drain_pc", pc, 32'h100);
        tick();
        check_eq("post_drain_addr", imem_addr, 32'h100);
        check_eq("post_drain_valid", 32'(instr_valid), 32'd0);
        check_eq("post_drain_instr", instr, 32'hC000_0008);
        tick();
        check_eq("tgt_instr_pc", instr_pc, 32'h100);
        check_eq("tgt_instr", instr, 32'hC000_0100);

        // Redirect with ack and stall in the same cycle.
        imem_ack = 1'b0;
        settle();
        check_eq("pend_addr", imem_addr, 32'h104);
        tick();
        imem_ack       = 1'b1;
        stall_i        = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        settle();
        check_eq("rack_req", 32'(imem_req), 32'd1);
        tick();
        redirect_valid = 1'b0;
        stall_i        = 1'b0;
        settle();
        check_eq("rack_valid", 32'(instr_valid), 32'd0);
        check_eq("rack_addr", imem_addr, 32'h40);
        check_eq("rack_instr", instr, 32'hC000_0100);
        tick();
        check_eq("x40_instr_pc", instr_pc, 32'h40);

        // Redirect while the full buffer is stalled flushes it.
        stall_i        = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        settle();
        tick();
        redirect_valid = 1'b0;
        stall_i        = 1'b0;
        settle();
        check_eq("sflush_valid", 32'(instr_valid), 32'd0);
        check_eq("sflush_addr", imem_addr, 32'h80);

        // PC wraps at the top of the address space.
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        settle();
        tick();
        redirect_valid = 1'b0;
        settle();
        check_eq("wrap_top_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        check_eq("wrap_addr", imem_addr, 32'h0);
        check_eq("wrap_pc", pc, 32'h0);
        check_eq("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);

        // Misaligned redirect.
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        settle();
        tick();
        redirect_valid = 1'b0;
        settle();
`ifdef RISC_FETCH_ALIGN_CHECK_EN
        check_eq("mis_trap", 32'(misalign_trap), 32'd1);
        check_eq("mis_pc", pc, 32'h8);
        check_eq("mis_instr_pc", instr_pc, 32'h4);
`else
        check_eq("mis_trap", 32'(misalign_trap), 32'd0);
        check_eq("mis_addr", imem_addr, 32'h100);
        check_eq("mis_valid", 32'(instr_valid), 32'd0);
`endif
        tick();
        check_eq("mis_trap_end", 32'(misalign_trap), 32'd0);

        // Reset while a request is outstanding.
        imem_ack = 1'b0;
        settle();
        check_eq("pre_rst_req", 32'(imem_req), 32'd1);
        tick();
        reset = 1'b1;
        settle();
        check_eq("mid_rst_req_hold", 32'(imem_req), 32'd1);
        tick();
        check_eq("mid_rst_req", 32'(imem_req), 32'd0);
        check_eq("mid_rst_pc", pc, 32'h0);
        check_eq("mid_rst_valid", 32'(instr_valid), 32'd0);
        reset = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
